// File: rtl/video_arb_pkg.sv
// Shared types for the video DRAM read-slot arbiter: owner tags, FSM states
// and default parameters.
package video_arb_pkg;

  localparam int unsigned AW_DEF     = 21;
  localparam int unsigned RD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_GFX  = 2'd1,
    OWN_TM   = 2'd2,
    OWN_TS   = 2'd3
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GFX  = 1'b1
  } state_e;

endpackage

// File: rtl/video_arb_tagpipe.sv
// Delay line of slot owner tags; the tag leaving the pipe yields that owner's
// data-valid strobe exactly RD_LAT cycles after its grant.
module video_arb_tagpipe
  import video_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic   clk,
  input  logic   clr_n,
  input  owner_e tag_in,
  output logic   gfx_next,
  output logic   tm_next,
  output logic   ts_next
);

  owner_e pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pipe[i] <= OWN_NONE;
    end else begin
      pipe[0] <= tag_in;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Gated by clr_n so in-flight strobes vanish in the reset cycle itself.
  always_comb begin
    gfx_next = 1'b0;
    tm_next  = 1'b0;
    ts_next  = 1'b0;
    if (clr_n) begin
      case (pipe[RD_LAT-1])
        OWN_GFX: gfx_next = 1'b1;
        OWN_TM:  tm_next  = 1'b1;
        OWN_TS:  ts_next  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/video_dram_arb.sv
// Video DRAM read-slot arbiter: graphics bursts take absolute priority,
// tilemap and TS share the remaining slots round-robin.
module video_dram_arb
  import video_arb_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          slot_stb,
  input  logic          line_start_s,
  input  logic          gfx_go,
  input  logic [AW-1:0] gfx_addr,
  input  logic [4:0]    gfx_bw,
  output logic          gfx_pre_next,
  output logic          gfx_next,
  input  logic          tm_req,
  input  logic [AW-1:0] tm_addr,
  output logic          tm_pre_next,
  output logic          tm_next,
  input  logic          ts_req,
  input  logic [AW-1:0] ts_addr,
  output logic          ts_pre_next,
  output logic          ts_next,
  output logic          dram_req,
  output logic [AW-1:0] dram_addr,
  output logic          gfx_busy
);

  state_e        state, state_nxt;
  logic [AW-1:0] ptr;
  logic [5:0]    rem;
  logic          rr;
  logic          gfx_grant;
  owner_e        grant_own;

  always_comb begin
    gfx_grant = res_n && (state == ST_GFX) && slot_stb && !line_start_s;
    grant_own = OWN_NONE;
    if (gfx_grant) begin
      grant_own = OWN_GFX;
    end else if (res_n && slot_stb) begin
      if (tm_req && ts_req) grant_own = rr ? OWN_TS : OWN_TM;
      else if (tm_req)      grant_own = OWN_TM;
      else if (ts_req)      grant_own = OWN_TS;
    end
  end

  always_comb begin
    dram_req     = (grant_own != OWN_NONE);
    gfx_pre_next = (grant_own == OWN_GFX);
    tm_pre_next  = (grant_own == OWN_TM);
    ts_pre_next  = (grant_own == OWN_TS);
    dram_addr    = '0;
    case (grant_own)
      OWN_GFX: dram_addr = ptr;
      OWN_TM:  dram_addr = tm_addr;
      OWN_TS:  dram_addr = ts_addr;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (gfx_go) state_nxt = ST_GFX;
      ST_GFX: begin
        if (line_start_s)                       state_nxt = ST_IDLE;
        else if (gfx_grant && (rem == 6'd1))    state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      rem   <= '0;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && gfx_go) begin
        ptr <= gfx_addr;
        rem <= {1'b0, gfx_bw} + 6'd1;
      end else if (gfx_grant) begin
        ptr <= ptr + AW'(1);
        rem <= rem - 6'd1;
      end
      if (grant_own == OWN_TM) rr <= 1'b1;
      if (grant_own == OWN_TS) rr <= 1'b0;
    end
  end

  assign gfx_busy = (state == ST_GFX);

  video_arb_tagpipe #(.RD_LAT(RD_LAT)) u_tagpipe (
    .clk      (clk),
    .clr_n    (res_n),
    .tag_in   (grant_own),
    .gfx_next (gfx_next),
    .tm_next  (tm_next),
    .ts_next  (ts_next)
  );

endmodule

// File: doc/video_dram_arb.md
# video_dram_arb

Sequences the DRAM video read slot between three requesters inside the video subsystem: the graphics fetcher, the tilemap reader and the TS sprite/tile renderer. Graphics fetches are bursts started by a go pulse and have absolute priority. Tilemap and TS requests share the remaining slots round-robin. For each granted slot the block drives one DRAM address, returns a pre-next strobe to the owner in the grant cycle, and a next (data-valid) strobe exactly RD_LAT cycles later.

## Interface
- AW, 21, DRAM word address width
- RD_LAT, 2, cycles from grant to read data valid on the shared data bus (1..7)
- clk  in  1  system clock
- res_n  in  1  reset, synchronous, active-low
- slot_stb  in  1  DRAM controller offers one video read slot this cycle
- line_start_s  in  1  line start; aborts an active graphics burst
- gfx_go  in  1  start graphics burst (sampled in IDLE only)
- gfx_addr  in  AW  burst start address, latched with gfx_go
- gfx_bw  in  5  burst length minus one (1..32 words)
- gfx_pre_next  out  1  graphics word granted this cycle
- gfx_next  out  1  graphics read data valid this cycle
- tm_req  in  1  tilemap read request (level, held until tm_pre_next)
- tm_addr  in  AW  tilemap address
- tm_pre_next  out  1  tilemap granted this cycle
- tm_next  out  1  tilemap data valid
- ts_req  in  1  TS render read request (level, held until ts_pre_next)
- ts_addr  in  AW  TS address
- ts_pre_next  out  1  TS granted this cycle
- ts_next  out  1  TS data valid
- dram_req  out  1  read issued in this slot
- dram_addr  out  AW  read address (don't-care when dram_req=0)
- gfx_busy  out  1  graphics burst in progress

## Operation
- States: IDLE, GFX.
- IDLE, gfx_go=1: latch gfx_addr into `ptr` and gfx_bw+1 into `rem` (6 bit), go to GFX. The slot in that same cycle is not a graphics grant; it is arbitrated between TM and TS.
- GFX, slot_stb=1, line_start_s=0: grant GFX, dram_addr=ptr, then ptr+1 (wraps modulo 2^AW) and rem-1. If rem==1, return to IDLE on the same edge. gfx_go is ignored while in GFX, including the cycle of the last grant.
- GFX, line_start_s=1: go to IDLE and drop the remaining words. No GFX grant occurs that cycle, even when slot_stb=1; that slot goes to TM/TS. Strobes already in the tag pipe still deliver.
- TM/TS arbitration applies when slot_stb=1 and no GFX grant:
  - Both requesting: grant the side selected by `rr` (0=TM, 1=TS), then set rr to the other side.
  - One requesting: grant it, then set rr to the other side.
  - None requesting: dram_req=0 and rr is unchanged.
- A requester may drop its req before pre_next without penalty. Its address is sampled only in the grant cycle.
- Every grant pushes an owner tag (NONE/GFX/TM/TS) into an RD_LAT-deep pipe. The tag at the pipe output produces exactly one matching *_next pulse.
- At most one pre_next and one next are asserted per cycle.

## Timing
- dram_req, dram_addr and *_pre_next are combinational from registered state, req inputs and slot_stb. All are asserted in the slot_stb cycle.
- *_next is asserted exactly RD_LAT cycles after the matching pre_next, with no bubbles and no reordering.
- gfx_busy equals (state==GFX), registered.
- Back-to-back slot_stb on consecutive cycles are all usable. A 32-word burst with slot_stb every cycle completes in 32 grant cycles.
- Reset values:
  - state=IDLE, ptr=0, rem=0, rr=0, tag pipe all NONE.
  - All outputs 0; dram_addr=0.
- Reset mid-burst or with tags in flight: the burst is abandoned and pending *_next pulses are discarded.

## Structure
- Package video_arb_pkg: owner enum (2 bit: NONE=0, GFX=1, TM=2, TS=3), state encoding, RD_LAT default.
- Sub-module video_arb_tagpipe: parameterised RD_LAT shift register of owner tags with synchronous active-low clear, plus a one-hot decode to gfx_next/tm_next/ts_next.
- Grant logic and the burst counter live in video_dram_arb.

## Test plan
- gfx_go with gfx_addr=0x1000 and gfx_bw=3, slot_stb every cycle: four grants at 0x1000..0x1003, then IDLE. gfx_next pulses follow each grant at +2 cycles.
- Burst active, with tm_req=1 and ts_req=1 held throughout: no TM/TS grant until the burst ends. Afterwards grants alternate TM, TS, TM… starting with TM.
- Line start mid-burst: gfx_bw=7, line_start_s asserted after 3 grants in the same cycle as slot_stb. No GFX grant occurs that cycle and ts_req wins the slot. Exactly 3 gfx_next pulses are seen.
- Address wrap: gfx_addr=0x1FFFFF with gfx_bw=1 gives addresses 0x1FFFFF then 0x000000.
- Sparse slots: slot_stb every 4th cycle with only tm_req=1. tm_pre_next occurs only on slot cycles and rr flips to TS each time. A subsequent simultaneous request is granted to TS.
- Reset mid-flight: res_n=0 one cycle after a grant. No *_next pulses follow, all outputs are 0, and a new gfx_go after reset starts cleanly.
